// File: rtl/vscale_hasti_wait_sram_pkg.sv
// Shared HASTI slave definitions: transfer/size/response codes,
// slave FSM state encodings and the byte-lane mask helper.
package vscale_hasti_wait_sram_pkg;

   localparam logic [1:0] HASTI_TRANS_IDLE   = 2'b00;
   localparam logic [1:0] HASTI_TRANS_BUSY   = 2'b01;
   localparam logic [1:0] HASTI_TRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HASTI_TRANS_SEQ    = 2'b11;

   localparam logic [2:0] HASTI_SIZE_BYTE = 3'd0;
   localparam logic [2:0] HASTI_SIZE_HALF = 3'd1;
   localparam logic [2:0] HASTI_SIZE_WORD = 3'd2;

   localparam logic HASTI_RESP_OKAY  = 1'b0;
   localparam logic HASTI_RESP_ERROR = 1'b1;

   typedef enum logic [2:0] {
      HASTI_SLAVE_ST_IDLE = 3'd0,
      HASTI_SLAVE_ST_WAIT = 3'd1,
      HASTI_SLAVE_ST_DONE = 3'd2,
      HASTI_SLAVE_ST_ERR1 = 3'd3,
      HASTI_SLAVE_ST_ERR2 = 3'd4
   } hasti_slave_st_e;

   // Byte lanes touched by an aligned access of the given size.
   function automatic logic [3:0] lane_mask(
      input logic [1:0] size,
      input logic [1:0] lsb
   );
      logic [3:0] m;
      m = 4'b1111;
      case (size)
         2'd0:    m = 4'b0001 << lsb;
         2'd1:    m = lsb[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/vscale_sram_byte_array.sv
// NWORDS x 32 storage with per-byte write enables.
// Ports: clk, we (4 lane enables), addr (word index),
//        wdata (sync write), rdata (async read of addr).
module vscale_sram_byte_array #(
   parameter int NWORDS = 1024,
   parameter int AW     = $clog2(NWORDS)
) (
   input  logic          clk,
   input  logic [3:0]    we,
   input  logic [AW-1:0] addr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [31:0] mem [NWORDS];

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/vscale_hasti_wait_sram.sv
// AHB-Lite (HASTI) slave SRAM with programmable data-phase waits
// and a two-cycle ERROR response for bad accesses.
// Ports: clk/reset (sync, active-high); haddr, hwrite, hsize,
//        hburst, hmastlock, hprot, htrans, hwdata from master;
//        hrdata, hready, hresp back to master.
module vscale_hasti_wait_sram
   import vscale_hasti_wait_sram_pkg::*;
#(
   parameter int          NWORDS      = 1024,
   parameter int          WAIT_CYCLES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] haddr,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic        hmastlock,
   input  logic [3:0]  hprot,
   input  logic [1:0]  htrans,
   input  logic [31:0] hwdata,
   output logic [31:0] hrdata,
   output logic        hready,
   output logic        hresp
);

   localparam int IW = $clog2(NWORDS);
   localparam logic [32:0] LIMIT =
      {1'b0, BASE_ADDR} + 33'(4 * NWORDS);
   localparam logic [3:0] WLOAD =
      (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam bit HAS_WAIT = (WAIT_CYCLES > 0);

   hasti_slave_st_e state;
   hasti_slave_st_e state_nxt;

   logic [3:0]    cnt;
   logic [IW-1:0] idx;
   logic          wr_q;
   logic [3:0]    be_q;

   logic [31:0] offset;
   logic        in_range;
   logic        bad;
   logic        accept;
   logic [3:0]  mem_we;
   logic [31:0] mem_rdata;

   // Address decode for the phase currently on the bus.
   assign offset   = haddr - BASE_ADDR;
   assign in_range = ({1'b0, haddr} >= {1'b0, BASE_ADDR})
                  && ({1'b0, haddr} < LIMIT);

   always_comb begin
      bad = 1'b0;
      if (!in_range)
         bad = 1'b1;
      else if (hsize > HASTI_SIZE_WORD)
         bad = 1'b1;
      else if (hsize == HASTI_SIZE_HALF && haddr[0])
         bad = 1'b1;
      else if (hsize == HASTI_SIZE_WORD && haddr[1:0] != 2'b00)
         bad = 1'b1;
   end

   assign accept = hready && htrans[1];

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= HASTI_SLAVE_ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic. DONE and ERR2 pipeline the next
   // address phase exactly like IDLE does.
   always_comb begin
      state_nxt = state;
      unique case (state)
         HASTI_SLAVE_ST_IDLE,
         HASTI_SLAVE_ST_DONE,
         HASTI_SLAVE_ST_ERR2: begin
            if (!accept)
               state_nxt = HASTI_SLAVE_ST_IDLE;
            else if (bad)
               state_nxt = HASTI_SLAVE_ST_ERR1;
            else if (HAS_WAIT)
               state_nxt = HASTI_SLAVE_ST_WAIT;
            else
               state_nxt = HASTI_SLAVE_ST_DONE;
         end
         HASTI_SLAVE_ST_WAIT: begin
            if (cnt == 4'd0) state_nxt = HASTI_SLAVE_ST_DONE;
         end
         HASTI_SLAVE_ST_ERR1: state_nxt = HASTI_SLAVE_ST_ERR2;
         default:             state_nxt = HASTI_SLAVE_ST_IDLE;
      endcase
   end

   // Wait counter: loaded on entry to WAIT, counts down to 0.
   always_ff @(posedge clk) begin
      if (reset)
         cnt <= 4'd0;
      else if (state_nxt == HASTI_SLAVE_ST_WAIT
            && state != HASTI_SLAVE_ST_WAIT)
         cnt <= WLOAD;
      else if (state == HASTI_SLAVE_ST_WAIT && cnt != 4'd0)
         cnt <= cnt - 4'd1;
   end

   // Data-phase capture of the accepted address phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         idx  <= '0;
         wr_q <= 1'b0;
         be_q <= 4'd0;
      end else if (accept) begin
         idx  <= offset[IW+1:2];
         wr_q <= hwrite;
         be_q <= lane_mask(hsize[1:0], haddr[1:0]);
      end
   end

   // Outputs. Writes commit on the DONE edge; reset drops them.
   always_comb begin
      hready = 1'b1;
      hresp  = HASTI_RESP_OKAY;
      mem_we = 4'd0;
      hrdata = 32'd0;
      unique case (state)
         HASTI_SLAVE_ST_WAIT: hready = 1'b0;
         HASTI_SLAVE_ST_ERR1: begin
            hready = 1'b0;
            hresp  = HASTI_RESP_ERROR;
         end
         HASTI_SLAVE_ST_ERR2: hresp = HASTI_RESP_ERROR;
         HASTI_SLAVE_ST_DONE: begin
            if (wr_q) mem_we = reset ? 4'd0 : be_q;
            else      hrdata = mem_rdata;
         end
         default: ;
      endcase
   end

   vscale_sram_byte_array #(
      .NWORDS (NWORDS),
      .AW     (IW)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (idx),
      .wdata (hwdata),
      .rdata (mem_rdata)
   );

   logic unused_ok;
   assign unused_ok = ^{hburst, hmastlock, hprot, htrans[0],
                        offset[31:IW+2], offset[1:0]};

endmodule

// File: tb/tb_vscale_hasti_wait_sram.sv
// Directed bench: one DUT at WAIT_CYCLES=0, one at WAIT_CYCLES=3,
// sharing the master-side inputs.
module tb_vscale_hasti_wait_sram;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst = 3'd0;
   logic        hmastlock = 1'b0;
   logic [3:0]  hprot = 4'd0;
   logic [1:0]  htrans;
   logic [31:0] hwdata;

   logic [31:0] hrdata0, hrdata3;
   logic        hready0, hready3;
   logic        hresp0, hresp3;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vscale_hasti_wait_sram #(.NWORDS(1024), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .reset(reset), .haddr(haddr), .hwrite(hwrite),
      .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
      .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
      .hrdata(hrdata0), .hready(hready0), .hresp(hresp0)
   );

   vscale_hasti_wait_sram #(.NWORDS(1024), .WAIT_CYCLES(3)) dut3 (
      .clk(clk), .reset(reset), .haddr(haddr), .hwrite(hwrite),
      .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock),
      .hprot(hprot), .htrans(htrans), .hwdata(hwdata),
      .hrdata(hrdata3), .hready(hready3), .hresp(hresp3)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic ap(input logic [31:0] a, input logic w,
                     input logic [2:0] s);
      haddr  = a;
      hwrite = w;
      hsize  = s;
      htrans = 2'b10;
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Leaves the caller at the negedge of dut3's completion cycle.
   task automatic wait_ready3(input string tag);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = hready3;
         if (!ok) @(posedge clk);
      end
      chk(tag, {31'd0, ok}, 32'd1);
   endtask

   initial begin
      reset  = 1'b1;
      haddr  = 32'd0;
      hwrite = 1'b0;
      hsize  = 3'd2;
      htrans = 2'b00;
      hwdata = 32'd0;
      repeat (2) @(posedge clk);
      smp();
      chk("rst_hready0", {31'd0, hready0}, 32'd1);
      chk("rst_hresp0",  {31'd0, hresp0},  32'd0);
      chk("rst_hrdata0", hrdata0, 32'd0);
      chk("rst_hready3", {31'd0, hready3}, 32'd1);
      chk("rst_hresp3",  {31'd0, hresp3},  32'd0);
      chk("rst_hrdata3", hrdata3, 32'd0);
      nxt();
      reset = 1'b0;
      nxt();

      // Waited read on dut3
      ap(32'h0, 1'b1, 3'd2);
      nxt();
      htrans = 2'b00;
      hwdata = 32'hCAFEF00D;
      wait_ready3("t2_wr_done");
      nxt();
      ap(32'h0, 1'b0, 3'd2);
      nxt();
      htrans = 2'b00;
      for (int k = 0; k < 3; k++) begin
         smp();
         chk("t2_wait_low", {31'd0, hready3}, 32'd0);
         nxt();
      end
      smp();
      chk("t2_ready_high", {31'd0, hready3}, 32'd1);
      chk("t2_hresp",      {31'd0, hresp3},  32'd0);
      chk("t2_hrdata",     hrdata3, 32'hCAFEF00D);
      nxt();

      // Reset during a waited write on dut3
      ap(32'h30, 1'b1, 3'd2);
      nxt();
      htrans = 2'b00;
      hwdata = 32'h01020304;
      wait_ready3("t6_pre_done");
      nxt();
      ap(32'h30, 1'b1, 3'd2);
      nxt();
      htrans = 2'b00;
      hwdata = 32'hFFFFFFFF;
      smp();
      chk("t6_in_wait", {31'd0, hready3}, 32'd0);
      reset = 1'b1;
      nxt();
      reset = 1'b0;
      smp();
      chk("t6_rst_hready", {31'd0, hready3}, 32'd1);
      chk("t6_rst_hresp",  {31'd0, hresp3},  32'd0);
      chk("t6_rst_hrdata", hrdata3, 32'd0);
      nxt();
      ap(32'h30, 1'b0, 3'd2);
      nxt();
      htrans = 2'b00;
      wait_ready3("t6_rd_done");
      chk("t6_rd_data", hrdata3, 32'h01020304);
      nxt();

      // Zero-wait write then read on dut0
      ap(32'h10, 1'b1, 3'd2);
      nxt();
      hwdata = 32'hDEADBEEF;
      ap(32'h10, 1'b0, 3'd2);
      smp();
      chk("t1_wr_ready", {31'd0, hready0}, 32'd1);
      chk("t1_wr_rdata", hrdata0, 32'd0);
      nxt();
      htrans = 2'b00;
      smp();
      chk("t1_rd_ready", {31'd0, hready0}, 32'd1);
      chk("t1_rd_data",  hrdata0, 32'hDEADBEEF);
      nxt();

      // Byte-lane merging
      ap(32'h20, 1'b1, 3'd2);
      nxt();
      hwdata = 32'h11223344;
      ap(32'h22, 1'b1, 3'd0);
      nxt();
      hwdata = 32'h00AA0000;
      ap(32'h20, 1'b1, 3'd1);
      nxt();
      hwdata = 32'h00005566;
      ap(32'h20, 1'b0, 3'd2);
      nxt();
      htrans = 2'b00;
      smp();
      chk("t3_merge", hrdata0, 32'h11AA5566);
      nxt();

      // Seed @0xC for the pipelined test
      ap(32'hC, 1'b1, 3'd2);
      nxt();
      htrans = 2'b00;
      hwdata = 32'h0BADF00D;
      nxt();

      // Error responses: range, half misaligned, oversize
      ap(32'h1002, 1'b1, 3'd2);
      hwdata = 32'hFFFFFFFF;
      nxt();
      htrans = 2'b00;
      smp();
      chk("t4a_err1_ready", {31'd0, hready0}, 32'd0);
      chk("t4a_err1_resp",  {31'd0, hresp0},  32'd1);
      nxt();
      ap(32'h3, 1'b1, 3'd1);
      smp();
      chk("t4a_err2_ready", {31'd0, hready0}, 32'd1);
      chk("t4a_err2_resp",  {31'd0, hresp0},  32'd1);
      nxt();
      htrans = 2'b00;
      smp();
      chk("t4b_err1_ready", {31'd0, hready0}, 32'd0);
      chk("t4b_err1_resp",  {31'd0, hresp0},  32'd1);
      nxt();
      ap(32'h20, 1'b1, 3'd3);
      smp();
      chk("t4b_err2_ready", {31'd0, hready0}, 32'd1);
      chk("t4b_err2_resp",  {31'd0, hresp0},  32'd1);
      nxt();
      htrans = 2'b00;
      smp();
      chk("t4c_err1_ready", {31'd0, hready0}, 32'd0);
      chk("t4c_err1_resp",  {31'd0, hresp0},  32'd1);
      nxt();
      smp();
      chk("t4c_err2_ready", {31'd0, hready0}, 32'd1);
      chk("t4c_err2_resp",  {31'd0, hresp0},  32'd1);
      nxt();
      ap(32'h20, 1'b0, 3'd2);
      nxt();
      htrans = 2'b00;
      smp();
      chk("t4_mem_kept", hrdata0, 32'h11AA5566);
      chk("t4_okay",     {31'd0, hresp0}, 32'd0);
      nxt();

      // Pipelined write / read / read
      ap(32'h8, 1'b1, 3'd2);
      nxt();
      hwdata = 32'h12345678;
      ap(32'h8, 1'b0, 3'd2);
      smp();
      chk("t5_wr_ready", {31'd0, hready0}, 32'd1);
      nxt();
      ap(32'hC, 1'b0, 3'd2);
      smp();
      chk("t5_rd8_ready", {31'd0, hready0}, 32'd1);
      chk("t5_rd8_data",  hrdata0, 32'h12345678);
      nxt();
      htrans = 2'b00;
      smp();
      chk("t5_rdC_ready", {31'd0, hready0}, 32'd1);
      chk("t5_rdC_data",  hrdata0, 32'h0BADF00D);
      nxt();
      smp();
      chk("t5_idle_rdata", hrdata0, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
